proc_imul_pipe: RTL

- Fully pipelined, parametrised integer multiply unit for the X stage of the 5-stage processor.
- Replaces the iterative variable-latency multiplier: fixed latency, one op per cycle, val/rdy on both sides.
- Adds all four RV32M multiply modes (MUL, MULH, MULHSU, MULHU).
- Adds a squash input that kills in-flight ops on redirects.

---
 rtl/proc_imul_pkg.sv | 12 +
 rtl/proc_imul_pipe_if.sv | 27 ++
 rtl/proc_imul_pipe_stage.sv | 64 ++++++
 rtl/proc_imul_pipe.sv | 111 +++++++++++
 4 files changed

// File: rtl/proc_imul_pkg.sv
// Shared definitions for the pipelined integer multiply unit.
// Holds the RV32M multiply function encoding used by all stages.
package proc_imul_pkg;

    typedef logic [1:0] imul_fn_t;

    localparam imul_fn_t IMUL_FN_MUL    = 2'd0;
    localparam imul_fn_t IMUL_FN_MULH   = 2'd1;
    localparam imul_fn_t IMUL_FN_MULHSU = 2'd2;
    localparam imul_fn_t IMUL_FN_MULHU  = 2'd3;

endpackage

// File: rtl/proc_imul_pipe_if.sv
// Request/response val/rdy bundle for the multiply unit.
// master: issues req_*, consumes resp_*; slave: the multiplier.
interface proc_imul_pipe_if #(
    parameter int p_nbits = 32
);
    import proc_imul_pkg::*;

    logic               req_val;
    logic               req_rdy;
    imul_fn_t           req_fn;
    logic [p_nbits-1:0] req_a;
    logic [p_nbits-1:0] req_b;
    logic               resp_val;
    logic               resp_rdy;
    logic [p_nbits-1:0] resp_msg;

    modport master (
        output req_val, req_fn, req_a, req_b, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_fn, req_a, req_b, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

endinterface

// File: rtl/proc_imul_pipe_stage.sv
// One multiply pipeline stage: valid bit, payload register and
// accumulation of p_ppb partial products starting at b bit p_base.
// Ports: clk, reset (async low), squash, in_adv/out_adv moves,
// in_* payload from upstream, v/fn/a/b/ps registered outputs.
module proc_imul_pipe_stage
    import proc_imul_pkg::*;
#(
    parameter int p_nbits = 32,
    parameter int p_ppb   = 8,
    parameter int p_base  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   squash,
    input  logic                   in_adv,
    input  logic                   out_adv,
    input  imul_fn_t               in_fn,
    input  logic [p_nbits:0]       in_a,
    input  logic [p_nbits-1:0]     in_b,
    input  logic [2*p_nbits+1:0]   in_ps,
    output logic                   v,
    output imul_fn_t               fn,
    output logic [p_nbits:0]       a,
    output logic [p_nbits-1:0]     b,
    output logic [2*p_nbits+1:0]   ps
);

    localparam int PW = 2 * p_nbits + 2;

    logic [PW-1:0] a_sx;
    logic [PW-1:0] ps_nx;

    assign a_sx = {{(p_nbits + 1){in_a[p_nbits]}}, in_a};

    always_comb begin
        ps_nx = in_ps;
        for (int j = 0; j < p_ppb; j++) begin
            if (in_b[p_base + j]) begin
                ps_nx = ps_nx + (a_sx << (p_base + j));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v  <= 1'b0;
            fn <= IMUL_FN_MUL;
            a  <= '0;
            b  <= '0;
            ps <= '0;
        end else begin
            if (squash)       v <= 1'b0;
            else if (in_adv)  v <= 1'b1;
            else if (out_adv) v <= 1'b0;
            if (in_adv) begin
                fn <= in_fn;
                a  <= in_a;
                b  <= in_b;
                ps <= ps_nx;
            end
        end
    end

endmodule

// File: rtl/proc_imul_pipe.sv
// Fully pipelined RV32M multiply unit, fixed p_nstages latency.
// Ports: clk, reset (async low), squash, s (slave val/rdy bundle).
module proc_imul_pipe
    import proc_imul_pkg::*;
#(
    parameter int p_nbits   = 32,
    parameter int p_nstages = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  squash,
    proc_imul_pipe_if.slave       s
);

    localparam int W   = p_nbits + 1;
    localparam int PW  = 2 * W;
    localparam int PPB = p_nbits / p_nstages;
    localparam int L   = p_nstages - 1;

    logic [p_nstages-1:0] v;
    logic [p_nstages-1:0] adv;
    imul_fn_t             fn_q [p_nstages];
    logic [W-1:0]         a_q  [p_nstages];
    logic [p_nbits-1:0]   b_q  [p_nstages];
    logic [PW-1:0]        ps_q [p_nstages];

    logic          accept;
    logic          a_sgn;
    logic          b_sgn;
    logic [W-1:0]  a_ext;
    logic [PW-1:0] a_sx0;
    logic [PW-1:0] ps0;

    // A tail stage may move only if the stage ahead is empty or moving.
    always_comb begin
        adv = '0;
        for (int i = L; i >= 0; i--) begin
            if (i == L) adv[i] = v[i] && s.resp_rdy;
            else        adv[i] = v[i] && (!v[i+1] || adv[i+1]);
        end
    end

    assign s.req_rdy = reset && !squash && (!v[0] || adv[0]);
    assign accept    = s.req_val && s.req_rdy;

    assign a_sgn = (s.req_fn == IMUL_FN_MULH) ||
                   (s.req_fn == IMUL_FN_MULHSU);
    assign b_sgn = (s.req_fn == IMUL_FN_MULH);
    assign a_ext = {a_sgn & s.req_a[p_nbits-1], s.req_a};
    assign a_sx0 = {{W{a_ext[W-1]}}, a_ext};

    // The extended sign bit of b weighs -2^p_nbits, so its partial
    // product seeds the sum; the stages only add the low p_nbits bits.
    assign ps0 = (b_sgn && s.req_b[p_nbits-1]) ?
                 -(a_sx0 << p_nbits) : '0;

    for (genvar i = 0; i < p_nstages; i++) begin : g_st
        if (i == 0) begin : g_first
            proc_imul_pipe_stage #(
                .p_nbits (p_nbits),
                .p_ppb   (PPB),
                .p_base  (0)
            ) u_st (
                .clk     (clk),
                .reset   (reset),
                .squash  (squash),
                .in_adv  (accept),
                .out_adv (adv[i]),
                .in_fn   (s.req_fn),
                .in_a    (a_ext),
                .in_b    (s.req_b),
                .in_ps   (ps0),
                .v       (v[i]),
                .fn      (fn_q[i]),
                .a       (a_q[i]),
                .b       (b_q[i]),
                .ps      (ps_q[i])
            );
        end else begin : g_next
            proc_imul_pipe_stage #(
                .p_nbits (p_nbits),
                .p_ppb   (PPB),
                .p_base  (i * PPB)
            ) u_st (
                .clk     (clk),
                .reset   (reset),
                .squash  (squash),
                .in_adv  (adv[i-1]),
                .out_adv (adv[i]),
                .in_fn   (fn_q[i-1]),
                .in_a    (a_q[i-1]),
                .in_b    (b_q[i-1]),
                .in_ps   (ps_q[i-1]),
                .v       (v[i]),
                .fn      (fn_q[i]),
                .a       (a_q[i]),
                .b       (b_q[i]),
                .ps      (ps_q[i])
            );
        end
    end

    assign s.resp_val = v[L];
    assign s.resp_msg = (fn_q[L] == IMUL_FN_MUL) ?
                        ps_q[L][p_nbits-1:0] :
                        ps_q[L][2*p_nbits-1:p_nbits];

    logic unused_tail;
    assign unused_tail = ^{a_q[L], b_q[L], ps_q[L][PW-1:2*p_nbits]};

endmodule
